// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Runs a full-width XOR/AND/OR/ADD by stepping one shared 4-bit combinational
// slice over N_PASS cycles, least-significant nibble first. The carry ripples
// between passes through a register. Commands arrive and results leave on
// valid/ready handshakes.
module alu_nibble_sequencer #(
  parameter int N_PASS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4*N_PASS-1:0]   cmd_a,
  input  logic [4*N_PASS-1:0]   cmd_b,
  output logic [3:0]            slice_a,
  output logic [3:0]            slice_b,
  output logic [1:0]            slice_op,
  output logic                  slice_cin,
  input  logic [3:0]            slice_y,
  input  logic                  slice_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*N_PASS-1:0]   res_y,
  output logic                  res_carry,
  output logic                  res_zero,
  output logic                  busy
);

  localparam int         DW     = 4 * N_PASS;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_y;
  logic [1:0]      r_op;
  logic            r_carry;
  logic [3:0]      r_p;
  logic            w_accept;
  logic            w_last;

  // Handshake qualifiers: accept only in IDLE; last pass when counter hits N_PASS-1.
  always_comb begin
    w_accept = (r_state == S_IDLE) && cmd_valid;
    w_last   = (r_p == 4'(N_PASS - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand/result datapath. Operands shift right one nibble per pass so the
  // current nibble is always bits [3:0]; the slice result enters at the top of
  // r_y and after N_PASS shifts every nibble sits in its final position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_op    <= 2'b00;
      r_carry <= 1'b0;
      r_p     <= 4'd0;
    end else if (w_accept) begin
      r_a     <= cmd_a;
      r_b     <= cmd_b;
      r_y     <= '0;
      r_op    <= cmd_op;
      r_carry <= 1'b0;
      r_p     <= 4'd0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_y     <= (r_y >> 4) | (DW'(slice_y) << (DW - 4));
      r_carry <= (r_op == OP_ADD) ? slice_cout : 1'b0;
      r_p     <= r_p + 4'd1;
    end else begin
      r_a     <= r_a;
      r_b     <= r_b;
      r_y     <= r_y;
      r_op    <= r_op;
      r_carry <= r_carry;
      r_p     <= r_p;
    end
  end

  // Output decode from registered state; slice inputs are forced to 0 outside RUN.
  always_comb begin
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_op  = 2'b00;
    slice_cin = 1'b0;
    if (r_state == S_RUN) begin
      slice_a   = r_a[3:0];
      slice_b   = r_b[3:0];
      slice_op  = r_op;
      slice_cin = (r_op == OP_ADD) ? r_carry : 1'b0;
    end else begin
      slice_a   = 4'h0;
      slice_b   = 4'h0;
      slice_op  = 2'b00;
      slice_cin = 1'b0;
    end
    cmd_ready = (r_state == S_IDLE);
    res_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    res_y     = r_y;
    res_carry = r_carry;
    res_zero  = (r_state == S_DONE) && (r_y == '0);
  end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Sequences one shared combinational 4-bit slice (XOR/AND/OR/ADD) over N_PASS cycles to execute full-width ALU operations. Default build gives 8-bit operations in 2 passes.
- Sits between the ALU command source and the nibble slice.
- Uses valid/ready handshakes on both sides: command in, result out.
- Drives the slice inputs, captures the slice result each pass, and ripples the carry between passes.

Parameters:
- N_PASS, 2: number of 4-bit passes; operand/result width DW = 4*N_PASS. Legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  operation: 00 XOR, 01 AND, 10 OR, 11 ADD.
- cmd_a  input  DW  operand A.
- cmd_b  input  DW  operand B.
- slice_a  output  4  nibble of A for the current pass.
- slice_b  output  4  nibble of B for the current pass.
- slice_op  output  2  operation to the slice.
- slice_cin  output  1  carry into the slice.
- slice_y  input  4  slice result, combinational from slice_* outputs.
- slice_cout  input  1  slice carry out.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_y  output  DW  full-width result.
- res_carry  output  1  final carry; ADD only, 0 for logic ops.
- res_zero  output  1  1 when res_y == 0.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - cmd_ready = 1; res_valid = 0; busy = 0.
  - res_y = 0, res_carry = 0, res_zero = 0.
  - slice_a = 0, slice_b = 0, slice_op = 0, slice_cin = 0.
  - Pass counter = 0; internal operand and accumulator registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid && cmd_ready, latch cmd_op, cmd_a, cmd_b; clear carry and pass counter; go to RUN.
- RUN (N_PASS cycles, pass index p = 0..N_PASS-1):
  - cmd_ready = 0.
  - slice_a = A[4p+3:4p], slice_b = B[4p+3:4p], slice_op = latched op.
  - slice_cin = the carry register when op == ADD, else 0. The carry register is 0 on p = 0.
  - On each clk edge: store slice_y into result bits [4p+3:4p]; carry register <= slice_cout when op == ADD, else 0; p increments.
  - After the edge that captures pass p = N_PASS-1, go to DONE.
- Slice output values:
  - Outside RUN, slice_* outputs hold 0.
  - The slice is combinational and must settle within one cycle.
- DONE:
  - res_valid = 1, and res_y / res_carry / res_zero are stable.
  - res_zero is computed from the registered res_y.
  - cmd_ready = 0.
  - When res_ready is high, return to IDLE and drop res_valid on the next cycle.
- Latency:
  - Command accepted at edge T; res_valid is high from T + N_PASS + 1 (cycle 3 after accept for N_PASS = 2).
  - Throughput is one command per N_PASS + 2 cycles. There is no accept in the same cycle as result handoff.
- Backpressure: res_ready held low keeps DONE indefinitely with outputs frozen; cmd_valid is ignored meanwhile.
- Command changes: cmd_a / cmd_b / cmd_op changing after the accept edge have no effect on the current operation.
- cmd_valid without ready: cmd_valid asserted while cmd_ready = 0 is not consumed; the source must hold it.
- ADD overflow: DW-bit wrap-around; the carry out of the top nibble is reported only on res_carry.
- Reset mid-operation: rst_n low in RUN or DONE returns immediately to the reset values and discards any partial result; the first command after rst_n deasserts is accepted normally.
- N_PASS = 1: RUN lasts one cycle, otherwise identical.

Test Plan:
- Reset then idle: cmd_ready = 1, res_valid = 0, busy = 0, slice_* all 0.
- XOR, A = 8'hA5, B = 8'h3C, res_ready = 1:
  - slice_a = 5 / slice_b = C on pass 0, then slice_a = A / slice_b = 3 on pass 1.
  - res_y = 8'h99, res_carry = 0, res_zero = 0, res_valid exactly 3 cycles after accept.
- ADD, A = 8'h0F, B = 8'h01:
  - slice_cin = 1 on pass 1.
  - res_y = 8'h10, res_carry = 0.
- ADD, A = 8'hFF, B = 8'h01: res_y = 8'h00, res_carry = 1, res_zero = 1.
- AND, A = 8'hF0, B = 8'h0F, with res_ready low for 5 cycles:
  - res_valid and res_y = 8'h00 held stable the whole time; res_zero = 1.
  - A second cmd_valid during the stall is not accepted until after handoff.
- ADD, A = 8'h88, B = 8'h88, rst_n pulsed low during pass 1:
  - All outputs return to reset values immediately.
  - The next command, OR with A = 8'h12, B = 8'h40, gives res_y = 8'h52 with no leftover carry.
